shdw_dump_ctrl: RTL and testbench

Parametrised shadow-scan dump controller: an IPIF register slave that drives the SPARC core's error-injection, reset, clock-enable and per-channel dump-enable controls. It sequences a dump across up to NUM_CH shadow chains and buffers the captured words in a FIFO for the MicroBlaze to drain over the bus. Everything, including the shadow side, runs on the bus clock.

---
 rtl/shdw_dump_ctrl_if.sv | 36 +++
 rtl/shdw_dump_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_shdw_dump_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shdw_dump_ctrl_if.sv
// shdw_dump_ctrl_if
// IPIF register-access bundle between the bus attachment (master) and the
// shadow dump controller (slave).
//   Bus2IP_Data   master->slave  write data, register bit n at index 31-n
//   Bus2IP_RdCE   master->slave  read chip enables, bit i selects register i
//   Bus2IP_WrCE   master->slave  write chip enables, bit i selects register i
//   IP2Bus_Data   slave->master  read data, meaningful only with RdAck
//   IP2Bus_RdAck  slave->master  one-cycle read acknowledge
//   IP2Bus_WrAck  slave->master  one-cycle write acknowledge
//   IP2Bus_Error  slave->master  error flag, qualified by either ack
//
// Handshake: a CE bit acts as "valid" for one access. The slave accepts an
// access on the first cycle a CE is high while no ack is pending, then
// returns exactly one ack pulse (with Data/Error) on the next cycle. A CE
// that stays high past its ack is the same access, not a new one; the
// master must drop the CE for a cycle, or raise a different CE, to issue
// another access.
interface shdw_dump_ctrl_if;
  logic [0:31] Bus2IP_Data;
  logic [0:7]  Bus2IP_RdCE;
  logic [0:7]  Bus2IP_WrCE;
  logic [0:31] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/shdw_dump_ctrl.sv
// shdw_dump_ctrl
// Shadow-scan dump controller. Register slave that drives the core's
// error-injection, shadow reset, clock-enable and dump-enable controls,
// walks the enabled shadow chains one at a time and buffers captured words
// in a FIFO that software drains through the FIFO_DATA register.
//   Bus2IP_Clk / Bus2IP_Resetn  clock, async active-low reset
//   bus          register access bundle (slave side)
//   err_en, err_ctrl, sh_rst, c_en   core control outputs
//   dump_en      one-hot chain select while dumping
//   sh_out, sh_out_vld, sh_out_done  per-chain shadow data/valid/last
//   irq          irq_en AND (done OR ovf)
//   state_dbg    current FSM state (0 idle, 1 dump, 2 done)
module shdw_dump_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ERR_W      = 12
) (
  input  logic                     Bus2IP_Clk,
  input  logic                     Bus2IP_Resetn,
  shdw_dump_ctrl_if.slave          bus,
  output logic                     err_en,
  output logic [ERR_W-1:0]         err_ctrl,
  output logic                     sh_rst,
  output logic                     c_en,
  output logic [NUM_CH-1:0]        dump_en,
  input  logic [NUM_CH*DATA_W-1:0] sh_out,
  input  logic [NUM_CH-1:0]        sh_out_vld,
  input  logic [NUM_CH-1:0]        sh_out_done,
  output logic                     irq,
  output logic [1:0]               state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DUMP = 2'd1, ST_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [7:0]        ch_q, ch_d;
  logic              c_en_q, c_en_d, sh_rst_q, sh_rst_d, err_en_q, err_en_d, irq_en_q, irq_en_d;
  logic [ERR_W-1:0]  err_ctrl_q, err_ctrl_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              ovf_q, ovf_d, done_q, done_d;
  logic [31:0]       wcnt_q, wcnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [0:7]        held_ce_q, held_ce_d;
  logic              rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [0:7]        ce;
  logic              acc, is_rd, start_s, abort_s, pop, push_ok, empty, full;
  logic              cur_vld, cur_done, nxt_found;
  logic [2:0]        idx;
  logic [31:0]       wdata, fifo_word, err_word, mask_word;
  logic [DATA_W-1:0] cur_word;
  logic [7:0]        nxt_ch, low_ch;

  // Bus bit 0 is the MSB of the ascending vector, so a plain assignment puts
  // register bit n at wdata[n].
  assign wdata = bus.Bus2IP_Data;

  always_comb begin
    state_d    = state_q;    ch_d       = ch_q;
    c_en_d     = c_en_q;     sh_rst_d   = sh_rst_q;
    err_en_d   = err_en_q;   irq_en_d   = irq_en_q;
    err_ctrl_d = err_ctrl_q; mask_d     = mask_q;
    ovf_d      = ovf_q;      done_d     = done_q;
    wcnt_d     = wcnt_q;     wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;   level_d    = level_q;
    rdata_d    = '0;         err_d      = 1'b0;
    start_s    = 1'b0;       abort_s    = 1'b0;
    pop        = 1'b0;

    empty = (level_q == '0);
    full  = (level_q == LW'(FIFO_DEPTH));
    fifo_word = '0;
    fifo_word[DATA_W-1:0] = mem_q[rd_ptr_q];
    err_word = '0;
    err_word[ERR_W-1:0] = err_ctrl_q;
    mask_word = '0;
    mask_word[NUM_CH-1:0] = mask_q;

    // Access detection: a CE vector equal to the one already serviced is the
    // same access held over, so it is only accepted once.
    ce    = bus.Bus2IP_RdCE | bus.Bus2IP_WrCE;
    is_rd = |bus.Bus2IP_RdCE;
    acc   = (|ce) && !rd_ack_q && !wr_ack_q && (ce != held_ce_q);
    if (acc)                  held_ce_d = ce;
    else if (ce != held_ce_q) held_ce_d = '0;
    else                      held_ce_d = held_ce_q;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (ce[i]) idx = 3'(i);
    rd_ack_d = acc && is_rd;
    wr_ack_d = acc && !is_rd;

    if (acc && is_rd) begin
      case (idx)
        3'd0: rdata_d = {26'd0, irq_en_q, 2'b00, err_en_q, sh_rst_q, c_en_q};
        3'd1: rdata_d = err_word;
        3'd2: rdata_d = mask_word;
        3'd3: rdata_d = {16'(level_q), ch_q, 4'd0, done_q, ovf_q, state_q};
        3'd4: begin
          if (empty) err_d = 1'b1;
          else begin
            rdata_d = fifo_word;
            pop     = 1'b1;
          end
        end
        3'd5: rdata_d = wcnt_q;
        3'd6: rdata_d = '0;
        default: err_d = 1'b1;
      endcase
    end else if (acc) begin
      case (idx)
        3'd0: begin
          c_en_d   = wdata[0];
          sh_rst_d = wdata[1];
          err_en_d = wdata[2];
          start_s  = wdata[3];
          abort_s  = wdata[4];
          irq_en_d = wdata[5];
        end
        3'd1: err_ctrl_d = wdata[ERR_W-1:0];
        3'd2: mask_d     = wdata[NUM_CH-1:0];
        3'd6: begin
          if (wdata[2]) ovf_d  = 1'b0;
          if (wdata[3]) done_d = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end

    // Selected chain and channel-advance lookup.
    cur_word = '0; cur_vld = 1'b0; cur_done = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 8'(c)) begin
        cur_word = sh_out[c*DATA_W +: DATA_W];
        cur_vld  = sh_out_vld[c];
        cur_done = sh_out_done[c];
      end
    end
    low_ch = '0; nxt_ch = '0; nxt_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) low_ch = 8'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ch    = 8'(i);
        nxt_found = 1'b1;
      end
    end

    // A full FIFO still takes a word when a pop frees a slot in the same cycle.
    push_ok = (state_q == ST_DUMP) && cur_vld && (!full || pop);
    if ((state_q == ST_DUMP) && cur_vld && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wcnt_q != '1) wcnt_d = wcnt_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(push_ok) - LW'(pop);

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          wcnt_d = '0;
          if (mask_q != '0) begin
            state_d = ST_DUMP;
            ch_d    = low_ch;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DUMP: begin
        if (cur_done) begin
          if (nxt_found) ch_d = nxt_ch;
          else           state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!abort_s) done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_s) state_d = ST_IDLE;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q  <= ST_IDLE;  ch_q     <= '0;
      c_en_q   <= 1'b0;     sh_rst_q <= 1'b1;
      err_en_q <= 1'b0;     irq_en_q <= 1'b0;
      err_ctrl_q <= '0;     mask_q   <= '0;
      ovf_q    <= 1'b0;     done_q   <= 1'b0;
      wcnt_q   <= '0;       wr_ptr_q <= '0;
      rd_ptr_q <= '0;       level_q  <= '0;
      held_ce_q <= '0;      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;     err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;  ch_q     <= ch_d;
      c_en_q   <= c_en_d;   sh_rst_q <= sh_rst_d;
      err_en_q <= err_en_d; irq_en_q <= irq_en_d;
      err_ctrl_q <= err_ctrl_d; mask_q <= mask_d;
      ovf_q    <= ovf_d;    done_q   <= done_d;
      wcnt_q   <= wcnt_d;   wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d; level_q  <= level_d;
      held_ce_q <= held_ce_d; rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d; err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array carries no reset; level/pointers define what is valid.
  always_ff @(posedge Bus2IP_Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= cur_word;
  end

  assign err_en           = err_en_q;
  assign err_ctrl         = err_ctrl_q;
  assign sh_rst           = sh_rst_q;
  assign c_en             = c_en_q && (state_q == ST_IDLE);
  assign dump_en          = (state_q == ST_DUMP) ? (NUM_CH'(1) << ch_q) : '0;
  assign irq              = irq_en_q && (done_q || ovf_q);
  assign state_dbg        = state_q;
  assign bus.IP2Bus_Data  = rdata_q;
  assign bus.IP2Bus_RdAck = rd_ack_q;
  assign bus.IP2Bus_WrAck = wr_ack_q;
  assign bus.IP2Bus_Error = err_q;
endmodule

// File: tb/tb_shdw_dump_ctrl.sv
module tb_shdw_dump_ctrl;
  localparam int NUM_CH = 4, DATA_W = 32, FIFO_DEPTH = 16, ERR_W = 12;
  localparam int R_CTRL = 0, R_ERR = 1, R_MASK = 2, R_STAT = 3, R_FIFO = 4, R_WCNT = 5, R_CLR = 6, R_RSV = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shdw_dump_ctrl_if bus_if();
  logic                     err_en, sh_rst, c_en, irq;
  logic [ERR_W-1:0]         err_ctrl;
  logic [NUM_CH-1:0]        dump_en, sh_out_vld, sh_out_done;
  logic [NUM_CH*DATA_W-1:0] sh_out;
  logic [1:0]               state_dbg;

  shdw_dump_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ERR_W(ERR_W)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .bus(bus_if),
    .err_en(err_en), .err_ctrl(err_ctrl), .sh_rst(sh_rst), .c_en(c_en), .dump_en(dump_en),
    .sh_out(sh_out), .sh_out_vld(sh_out_vld), .sh_out_done(sh_out_done),
    .irq(irq), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  int rd_issued = 0, rd_seen = 0, wr_issued = 0, wr_seen = 0;
  logic [32:0] exp_q[$];     // {error, data} per read
  logic        exp_wr_q[$];  // error per write

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    logic [31:0] d;
    if (bus_if.IP2Bus_RdAck) begin
      checks++;
      d = bus_if.IP2Bus_Data;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected_ack: got data 0x%08h err %0b, no read outstanding", d, bus_if.IP2Bus_Error);
      end else begin
        e = exp_q.pop_front();
        if ({bus_if.IP2Bus_Error, d} !== e) begin
          errors++;
          $display("FAIL rd#%0d: got err %0b data 0x%08h expected err %0b data 0x%08h",
                   rd_seen, bus_if.IP2Bus_Error, d, e[32], e[31:0]);
        end
      end
      rd_seen++;
    end
    if (bus_if.IP2Bus_WrAck) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected_ack: got err %0b, no write outstanding", bus_if.IP2Bus_Error);
      end else if (bus_if.IP2Bus_Error !== exp_wr_q.pop_front()) begin
        errors++;
        $display("FAIL wr#%0d: got err %0b expected opposite", wr_seen, bus_if.IP2Bus_Error);
      end
      wr_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // Every task starts and ends 1 time unit after a rising edge.
  task automatic wait_acks();
    int t = 0;
    while ((rd_seen < rd_issued || wr_seen < wr_issued) && t < 10) begin
      @(negedge clk); #1;
      t++;
    end
    if (rd_seen < rd_issued || wr_seen < wr_issued) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got %0d/%0d acks expected %0d/%0d", rd_seen, wr_seen, rd_issued, wr_issued);
      rd_seen = rd_issued; wr_seen = wr_issued;
      exp_q.delete(); exp_wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic bus_rd(input int idx, input logic [31:0] d, input logic e, input int hold = 1);
    exp_q.push_back({e, d});
    rd_issued++;
    bus_if.Bus2IP_RdCE = '0;
    bus_if.Bus2IP_RdCE[idx] = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus_if.Bus2IP_RdCE = '0;
    wait_acks();
  endtask

  task automatic bus_wr(input int idx, input logic [31:0] d, input logic e);
    exp_wr_q.push_back(e);
    wr_issued++;
    bus_if.Bus2IP_Data = d;
    bus_if.Bus2IP_WrCE = '0;
    bus_if.Bus2IP_WrCE[idx] = 1'b1;
    @(posedge clk); #1;
    bus_if.Bus2IP_WrCE = '0;
    wait_acks();
  endtask

  task automatic sh_word(input int ch, input logic [31:0] d, input logic v, input logic dn);
    sh_out[ch*DATA_W +: DATA_W] = d;
    sh_out_vld[ch]  = v;
    sh_out_done[ch] = dn;
    @(posedge clk); #1;
    sh_out_vld  = '0;
    sh_out_done = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.Bus2IP_Data = '0;
    bus_if.Bus2IP_RdCE = '0;
    bus_if.Bus2IP_WrCE = '0;
    sh_out = '0; sh_out_vld = '0; sh_out_done = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sh_rst", 32'(sh_rst), 32'd1);
    chk("rst_c_en", 32'(c_en), 32'd0);
    chk("rst_dump_en", 32'(dump_en), 32'd0);
    chk("rst_err_ctrl", 32'({err_en, err_ctrl}), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Reset register values and reserved/RO access errors
    bus_rd(R_STAT, 32'h0, 1'b0);
    bus_rd(R_CTRL, 32'h2, 1'b0);
    bus_rd(R_RSV, 32'h0, 1'b1);
    bus_rd(R_CLR, 32'h0, 1'b0);
    bus_wr(R_RSV, 32'h1, 1'b1);
    bus_wr(R_STAT, 32'hFFFF_FFFF, 1'b1);
    bus_wr(R_FIFO, 32'h1234, 1'b1);
    bus_rd(R_STAT, 32'h0, 1'b0);

    // Control outputs
    bus_wr(R_CTRL, 32'h1, 1'b0);
    chk("c_en_on", 32'(c_en), 32'd1);
    chk("sh_rst_off", 32'(sh_rst), 32'd0);
    bus_wr(R_ERR, 32'hABC, 1'b0);
    chk("err_ctrl", 32'(err_ctrl), 32'hABC);
    bus_wr(R_ERR, 32'hFFFF_F123, 1'b0);
    bus_rd(R_ERR, 32'h123, 1'b0);
    bus_wr(R_ERR, 32'hABC, 1'b0);
    bus_wr(R_MASK, 32'hFFFF_FFF5, 1'b0);
    bus_rd(R_MASK, 32'h5, 1'b0);

    // Dump over channels 0 and 2
    bus_wr(R_CTRL, 32'h9, 1'b0);
    chk("dump_en_ch0", 32'(dump_en), 32'h1);
    chk("c_en_dump", 32'(c_en), 32'd0);
    bus_rd(R_CTRL, 32'h1, 1'b0);
    sh_word(0, 32'h1111_0001, 1'b1, 1'b0);
    sh_word(0, 32'h1111_0002, 1'b1, 1'b0);
    sh_word(1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    sh_word(0, 32'h1111_0003, 1'b1, 1'b0);
    sh_word(0, 32'h0, 1'b0, 1'b1);
    chk("dump_en_ch2", 32'(dump_en), 32'h4);
    sh_word(2, 32'h2222_0001, 1'b1, 1'b0);
    sh_word(2, 32'h2222_0002, 1'b1, 1'b1);
    chk("state_done", 32'(state_dbg), 32'd2);
    chk("dump_en_done", 32'(dump_en), 32'h0);
    idle(1);
    chk("c_en_back", 32'(c_en), 32'd1);
    chk("irq_masked", 32'(irq), 32'd0);
    bus_rd(R_STAT, 32'h0005_0208, 1'b0);
    bus_rd(R_WCNT, 32'd5, 1'b0);

    // Drain in push order, then underflow
    bus_rd(R_FIFO, 32'h1111_0001, 1'b0);
    bus_rd(R_FIFO, 32'h1111_0002, 1'b0);
    bus_rd(R_FIFO, 32'h1111_0003, 1'b0);
    bus_rd(R_FIFO, 32'h2222_0001, 1'b0);
    bus_rd(R_FIFO, 32'h2222_0002, 1'b0);
    bus_rd(R_STAT, 32'h0000_0208, 1'b0);
    bus_rd(R_FIFO, 32'h0, 1'b1);
    bus_wr(R_CLR, 32'h8, 1'b0);
    bus_rd(R_STAT, 32'h0000_0200, 1'b0);

    // Overflow: 18 words into a 16-entry FIFO on channel 1
    bus_wr(R_MASK, 32'h2, 1'b0);
    bus_wr(R_CTRL, 32'h9, 1'b0);
    chk("dump_en_ch1", 32'(dump_en), 32'h2);
    for (int i = 0; i < 18; i++) sh_word(1, 32'h3000 + 32'(i), 1'b1, 1'b0);
    bus_rd(R_STAT, 32'h0010_0105, 1'b0);
    bus_rd(R_WCNT, 32'd16, 1'b0);
    bus_wr(R_CLR, 32'h4, 1'b0);
    bus_rd(R_STAT, 32'h0010_0101, 1'b0);
    bus_wr(R_CTRL, 32'h11, 1'b0);
    chk("abort_ovf_state", 32'(state_dbg), 32'd0);
    chk("abort_ovf_dump_en", 32'(dump_en), 32'h0);
    for (int i = 0; i < 16; i++) bus_rd(R_FIFO, 32'h3000 + 32'(i), 1'b0);
    bus_rd(R_STAT, 32'h0000_0100, 1'b0);

    // Abort mid-dump after two words
    bus_wr(R_MASK, 32'h1, 1'b0);
    bus_wr(R_CTRL, 32'h9, 1'b0);
    sh_word(0, 32'h4000_0001, 1'b1, 1'b0);
    sh_word(0, 32'h4000_0002, 1'b1, 1'b0);
    bus_wr(R_CTRL, 32'h11, 1'b0);
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_dump_en", 32'(dump_en), 32'h0);
    bus_rd(R_STAT, 32'h0002_0000, 1'b0);
    bus_rd(R_FIFO, 32'h4000_0001, 1'b0);
    bus_rd(R_FIFO, 32'h4000_0002, 1'b0);

    // Interrupt, same-cycle vld+done on last channel, held CE
    bus_wr(R_CTRL, 32'h21, 1'b0);
    chk("irq_idle", 32'(irq), 32'd0);
    bus_wr(R_MASK, 32'h8, 1'b0);
    bus_wr(R_CTRL, 32'h29, 1'b0);
    chk("dump_en_ch3", 32'(dump_en), 32'h8);
    sh_word(3, 32'h5555_AAAA, 1'b1, 1'b1);
    chk("state_done_last", 32'(state_dbg), 32'd2);
    idle(1);
    chk("irq_set", 32'(irq), 32'd1);
    bus_rd(R_STAT, 32'h0001_0308, 1'b0);
    bus_rd(R_WCNT, 32'd1, 1'b0);
    bus_rd(R_FIFO, 32'h5555_AAAA, 1'b0, 3);
    idle(1);
    bus_rd(R_FIFO, 32'h0, 1'b1);
    chk("irq_hold", 32'(irq), 32'd1);
    bus_wr(R_CLR, 32'h8, 1'b0);
    chk("irq_clr", 32'(irq), 32'd0);

    // Start with empty mask goes straight to DONE
    bus_wr(R_MASK, 32'h0, 1'b0);
    bus_wr(R_CTRL, 32'h9, 1'b0);
    bus_rd(R_STAT, 32'h0000_0308, 1'b0);

    // Asynchronous reset mid-dump
    bus_wr(R_MASK, 32'h1, 1'b0);
    bus_wr(R_CTRL, 32'h9, 1'b0);
    chk("dump_en_pre_rst", 32'(dump_en), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_dump_en", 32'(dump_en), 32'h0);
    chk("async_rst_sh_rst", 32'(sh_rst), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    bus_rd(R_STAT, 32'h0, 1'b0);
    bus_rd(R_CTRL, 32'h2, 1'b0);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
